// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous data memory.
// Round-robin on ties, optional lock for read-modify-write with a forced timeout.
module data_mem_arbiter #(
    parameter int N        = 10,
    parameter int M        = 32,
    parameter int LOCK_MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         p0_req,
    input  logic         p0_we,
    input  logic [N-1:0] p0_addr,
    input  logic [M-1:0] p0_wdata,
    input  logic         p0_lock,
    output logic         p0_gnt,
    output logic         p0_rvalid,
    output logic [M-1:0] p0_rdata,
    input  logic         p1_req,
    input  logic         p1_we,
    input  logic [N-1:0] p1_addr,
    input  logic [M-1:0] p1_wdata,
    input  logic         p1_lock,
    output logic         p1_gnt,
    output logic         p1_rvalid,
    output logic [M-1:0] p1_rdata,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [M-1:0] mem_wdata,
    input  logic [M-1:0] mem_rdata
);
    localparam int CW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t        r_state, w_next;
    logic          r_last_grant;
    logic [CW-1:0] r_lock_cnt;
    logic          r_rvalid0, r_rvalid1;
    logic          w_gnt0, w_gnt1, w_timeout;

    always_comb begin
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        w_next    = r_state;
        w_timeout = (r_state != IDLE) && (r_lock_cnt == LMAX);
        // Grants are suppressed in reset; the timeout cycle grants nobody.
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (p0_req && p1_req) begin
                        w_gnt0 = r_last_grant;
                        w_gnt1 = ~r_last_grant;
                    end else begin
                        w_gnt0 = p0_req;
                        w_gnt1 = p1_req;
                    end
                end
                LOCK0:   w_gnt0 = p0_req && !w_timeout;
                LOCK1:   w_gnt1 = p1_req && !w_timeout;
                default: ;
            endcase
        end
        if (w_gnt0)
            w_next = p0_lock ? LOCK0 : IDLE;
        else if (w_gnt1)
            w_next = p1_lock ? LOCK1 : IDLE;
        else if (w_timeout)
            w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_lock_cnt   <= '0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rvalid0 <= w_gnt0 && !p0_we;
            r_rvalid1 <= w_gnt1 && !p1_we;
            if (w_gnt0)
                r_last_grant <= 1'b0;
            else if (w_gnt1)
                r_last_grant <= 1'b1;
            else if (w_timeout)
                r_last_grant <= (r_state == LOCK1);
            // Counter runs only while locked; any cycle in or leaving IDLE restarts it.
            if (r_state == IDLE || w_next == IDLE)
                r_lock_cnt <= '0;
            else
                r_lock_cnt <= r_lock_cnt + 1'b1;
        end
    end

    assign p0_gnt    = w_gnt0;
    assign p1_gnt    = w_gnt1;
    assign p0_rvalid = r_rvalid0;
    assign p1_rvalid = r_rvalid1;
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;
    assign mem_we    = (w_gnt0 && p0_we) || (w_gnt1 && p1_we);
    assign mem_addr  = w_gnt1 ? p1_addr  : p0_addr;
    assign mem_wdata = w_gnt1 ? p1_wdata : p0_wdata;
endmodule
